ql_combo_sequencer: RTL



---
 rtl/ql_kbd_pkg.sv | 59 +++++
 rtl/ql_combo_sequencer_if.sv | 21 ++
 rtl/ql_rr_arbiter.sv | 31 +++
 rtl/ql_combo_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ql_kbd_pkg.sv
// QL keyboard matrix constants, combo table and sequencer state type.
package ql_kbd_pkg;

    // Matrix indices (row*8+col) of the keys the combo sequencer touches.
    localparam int QL_SHIFT = 56;
    localparam int QL_CTRL  = 57;
    localparam int QL_ALT   = 58;
    localparam int QL_LEFT  = 9;
    localparam int QL_UP    = 10;
    localparam int QL_RIGHT = 12;
    localparam int QL_DOWN  = 15;
    localparam int QL_F4    = 0;
    localparam int QL_F1    = 1;
    localparam int QL_F2    = 3;
    localparam int QL_F3    = 4;
    localparam int QL_F5    = 5;

    // Modifier mask layout {alt,ctrl,shift}.
    localparam logic [2:0] MOD_NONE  = 3'b000;
    localparam logic [2:0] MOD_SHIFT = 3'b001;
    localparam logic [2:0] MOD_CTRL  = 3'b010;
    localparam logic [2:0] MOD_ALT   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOD,
        ST_KEY,
        ST_REL
    } seq_state_t;

    typedef struct packed {
        logic [2:0] mods;
        logic [5:0] key;
    } combo_t;

    // Host keys that have no direct QL equivalent.
    localparam combo_t COMBO_BKSP = '{mods: MOD_CTRL,  key: 6'(QL_LEFT)};
    localparam combo_t COMBO_DEL  = '{mods: MOD_CTRL,  key: 6'(QL_RIGHT)};
    localparam combo_t COMBO_F6   = '{mods: MOD_SHIFT, key: 6'(QL_F1)};
    localparam combo_t COMBO_F7   = '{mods: MOD_SHIFT, key: 6'(QL_F2)};
    localparam combo_t COMBO_F8   = '{mods: MOD_SHIFT, key: 6'(QL_F3)};
    localparam combo_t COMBO_F9   = '{mods: MOD_SHIFT, key: 6'(QL_F4)};
    localparam combo_t COMBO_F10  = '{mods: MOD_SHIFT, key: 6'(QL_F5)};
    localparam combo_t COMBO_HOME = '{mods: MOD_ALT,   key: 6'(QL_LEFT)};
    localparam combo_t COMBO_END  = '{mods: MOD_ALT,   key: 6'(QL_RIGHT)};
    localparam combo_t COMBO_PGUP = '{mods: MOD_SHIFT, key: 6'(QL_UP)};
    localparam combo_t COMBO_PGDN = '{mods: MOD_SHIFT, key: 6'(QL_DOWN)};

    // Expand a modifier mask into its matrix bits.
    function automatic logic [63:0] mod_to_matrix(input logic [2:0] mods);
        logic [63:0] m;
        m = '0;
        m[QL_SHIFT] = mods[0];
        m[QL_CTRL]  = mods[1];
        m[QL_ALT]   = mods[2];
        return m;
    endfunction

endpackage

// File: rtl/ql_combo_sequencer_if.sv
// Request table in, matrix overlay and status out, for the combo sequencer.
interface ql_combo_sequencer_if #(
    parameter int NUM_REQ = 12
);
    logic [NUM_REQ-1:0]   req;
    logic [3*NUM_REQ-1:0] req_mod;
    logic [6*NUM_REQ-1:0] req_key;
    logic [63:0]          matrix_or;
    logic                 busy;
    logic [3:0]           active_id;

    modport master (
        output req, req_mod, req_key,
        input  matrix_or, busy, active_id
    );

    modport slave (
        input  req, req_mod, req_key,
        output matrix_or, busy, active_id
    );
endinterface

// File: rtl/ql_rr_arbiter.sv
// Round-robin arbiter: picks the lowest requesting index at or after ptr, wrapping.
module ql_rr_arbiter #(
    parameter int NUM_REQ = 12
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [3:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [3:0]         idx,
    output logic               valid
);
    // Distance from ptr (with wrap) ranks each requester; smallest distance wins.
    always_comb begin
        int off;
        int best;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        best  = NUM_REQ;
        off   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            off = (k >= int'(ptr)) ? k - int'(ptr) : k + NUM_REQ - int'(ptr);
            if (req[k] && off < best) begin
                best     = off;
                grant    = '0;
                grant[k] = 1'b1;
                idx      = 4'(k);
                valid    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ql_combo_sequencer.sv
// Plays modifier+key combos onto the QL matrix one at a time, timed in prescaler ticks.
module ql_combo_sequencer
    import ql_kbd_pkg::*;
#(
    parameter int NUM_REQ      = 12,
    parameter int TICK_DIV     = 13,
    parameter int SETTLE_TICKS = 15,
    parameter int MIN_HOLD     = 4,
    parameter int GAP_TICKS    = 2
) (
    input  logic                  clk,
    input  logic                  delay_reset,
    input  logic                  ce,
    ql_combo_sequencer_if.slave   bus
);
    localparam logic [7:0] SETTLE_L = 8'(SETTLE_TICKS);
    localparam logic [7:0] HOLD_L   = 8'(MIN_HOLD);
    localparam logic [7:0] GAP_L    = 8'(GAP_TICKS);

    logic [TICK_DIV-1:0] prescaler;
    logic                tick;
    seq_state_t          state;
    logic [7:0]          cnt;
    logic [7:0]          cnt_nx;
    logic [3:0]          ptr;
    logic [NUM_REQ-1:0]  grant_q;
    logic [2:0]          mods;
    logic [5:0]          key;
    logic [63:0]         key_bit;
    logic                req_held;
    logic [63:0]         matrix_q;
    logic                busy_q;
    logic [3:0]          active_id_q;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [3:0]          arb_idx;
    logic                arb_valid;
    logic [2:0]          mod_sel;
    logic [5:0]          key_sel;

    ql_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign tick     = ce && (prescaler == '1);
    assign cnt_nx   = (tick && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
    assign key_bit  = 64'd1 << key;
    assign req_held = |(bus.req & grant_q);

    assign bus.matrix_or = matrix_q;
    assign bus.busy      = busy_q;
    assign bus.active_id = active_id_q;

    // Pick the granted requester's modifier mask and key out of the static table.
    always_comb begin
        mod_sel = '0;
        key_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_grant[k]) begin
                mod_sel = mod_sel | bus.req_mod[3*k +: 3];
                key_sel = key_sel | bus.req_key[6*k +: 6];
            end
        end
    end

    // Free-running tick prescaler advanced by the clock enable.
    always_ff @(posedge clk or posedge delay_reset) begin
        if (delay_reset) prescaler <= '0;
        else if (ce)     prescaler <= prescaler + TICK_DIV'(1);
    end

    // Combo sequencer; outputs are computed for the state being entered.
    always_ff @(posedge clk or posedge delay_reset) begin
        if (delay_reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ptr         <= '0;
            grant_q     <= '0;
            mods        <= '0;
            key         <= '0;
            matrix_q    <= '0;
            busy_q      <= 1'b0;
            active_id_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state       <= ST_MOD;
                        cnt         <= '0;
                        grant_q     <= arb_grant;
                        mods        <= mod_sel;
                        key         <= key_sel;
                        active_id_q <= arb_idx;
                        ptr         <= (arb_idx == 4'(NUM_REQ-1)) ? 4'd0 : arb_idx + 4'd1;
                        matrix_q    <= mod_to_matrix(mod_sel);
                        busy_q      <= 1'b1;
                    end
                end
                ST_MOD: begin
                    // A request released before the key shows aborts without ever showing it.
                    if (!req_held) begin
                        state    <= ST_REL;
                        cnt      <= '0;
                        matrix_q <= '0;
                    end else if (mods == MOD_NONE || cnt_nx >= SETTLE_L) begin
                        state    <= ST_KEY;
                        cnt      <= '0;
                        matrix_q <= mod_to_matrix(mods) | key_bit;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                ST_KEY: begin
                    if (!req_held && cnt_nx >= HOLD_L) begin
                        state    <= ST_REL;
                        cnt      <= '0;
                        matrix_q <= '0;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                ST_REL: begin
                    if (cnt_nx >= GAP_L) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    matrix_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule
